// File: rtl/axi_drain_gate_pkg.sv
// Shared types for the AXI drain gate: the AXI channel/bus structs and the gate FSM state.
package ariane_axi;

  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 64;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef logic [IdWidth-1:0]   id_t;
  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [DataWidth-1:0] data_t;
  typedef logic [StrbWidth-1:0] strb_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } ax_chan_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
  } w_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    id_t        id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

endpackage

package std_cache_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } axi_gate_state_e;

endpackage

// File: rtl/axi_drain_gate_outstanding_cnt.sv
// Up/down counter of in-flight bursts; a lone decrement at zero holds and flags underflow.
module outstanding_cnt #(
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                inc,
  input  logic                dec,
  output logic [CntWidth-1:0] cnt,
  output logic                at_max,
  output logic                underflow
);

  logic [CntWidth-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (inc && !dec) begin
      cnt_q <= cnt_q + CntWidth'(1);
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CntWidth'(1);
    end
  end

  assign cnt       = cnt_q;
  assign at_max    = (cnt_q == CntWidth'(MaxOutstanding));
  assign underflow = dec & ~inc & (cnt_q == '0);

endmodule

// File: rtl/axi_drain_gate.sv
// AXI gate that stops new AR/AW on stall, drains in-flight bursts, then reports halted.
module axi_drain_gate
  import ariane_axi::*;
  import std_cache_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                stall_i,
  input  req_t                slv_req_i,
  output resp_t               slv_resp_o,
  output req_t                mst_req_o,
  input  resp_t               mst_resp_i,
  output logic                busy_o,
  output logic                halted_o,
  output logic [CntWidth-1:0] rd_cnt_o,
  output logic [CntWidth-1:0] wr_cnt_o,
  output logic                err_o
);

  axi_gate_state_e state_q, state_d;
  logic            halted_q;
  logic            ar_pend_q, aw_pend_q;
  logic            ar_block, aw_block;
  logic            err_q;
  logic            ar_hs, aw_hs, r_last_hs, b_hs;
  logic            rd_at_max, wr_at_max, rd_underflow, wr_underflow;

  // Pass-through with only the address-channel valid/ready gated.
  always_comb begin
    mst_req_o           = slv_req_i;
    mst_req_o.ar_valid  = slv_req_i.ar_valid & ~ar_block;
    mst_req_o.aw_valid  = slv_req_i.aw_valid & ~aw_block;
    slv_resp_o          = mst_resp_i;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & ~ar_block;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & ~aw_block;
  end

  assign ar_hs     = mst_req_o.ar_valid & mst_resp_i.ar_ready;
  assign aw_hs     = mst_req_o.aw_valid & mst_resp_i.aw_ready;
  assign r_last_hs = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;
  assign b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;

  outstanding_cnt #(
    .MaxOutstanding(MaxOutstanding),
    .CntWidth      (CntWidth)
  ) u_rd_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .inc      (ar_hs),
    .dec      (r_last_hs),
    .cnt      (rd_cnt_o),
    .at_max   (rd_at_max),
    .underflow(rd_underflow)
  );

  outstanding_cnt #(
    .MaxOutstanding(MaxOutstanding),
    .CntWidth      (CntWidth)
  ) u_wr_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .inc      (aw_hs),
    .dec      (b_hs),
    .cnt      (wr_cnt_o),
    .at_max   (wr_at_max),
    .underflow(wr_underflow)
  );

  // A forwarded but not yet accepted valid keeps its channel open until the handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ar_pend_q <= 1'b0;
      aw_pend_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ar_pend_q <= mst_req_o.ar_valid & ~mst_resp_i.ar_ready;
      aw_pend_q <= mst_req_o.aw_valid & ~mst_resp_i.aw_ready;
      if (rd_underflow || wr_underflow) begin
        err_q <= 1'b1;
      end
    end
  end

  assign busy_o = (rd_cnt_o != '0) | (wr_cnt_o != '0) | ar_pend_q | aw_pend_q;
  assign err_o  = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= RUN;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == HALTED);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (stall_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (!stall_i)     state_d = RUN;
        else if (!busy_o) state_d = HALTED;
      end
      HALTED: begin
        if (!stall_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    ar_block = ((state_q != RUN) | rd_at_max) & ~ar_pend_q;
    aw_block = ((state_q != RUN) | wr_at_max) & ~aw_pend_q;
  end

  assign halted_o = halted_q;

endmodule

// File: tb/tb_axi_drain_gate.sv
// Directed bench for axi_drain_gate with a per-cycle reference model and literal spot checks.
module tb_axi_drain_gate;
  import ariane_axi::*;

  localparam int unsigned Max = 8;
  localparam int unsigned CW  = $clog2(Max + 1);

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          stall_i;
  req_t          slv_req;
  resp_t         slv_resp;
  req_t          mst_req;
  resp_t         mst_resp;
  logic          busy, halted, err;
  logic [CW-1:0] rd_cnt, wr_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  axi_drain_gate #(
    .MaxOutstanding(Max),
    .CntWidth      (CW)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .stall_i   (stall_i),
    .slv_req_i (slv_req),
    .slv_resp_o(slv_resp),
    .mst_req_o (mst_req),
    .mst_resp_i(mst_resp),
    .busy_o    (busy),
    .halted_o  (halted),
    .rd_cnt_o  (rd_cnt),
    .wr_cnt_o  (wr_cnt),
    .err_o     (err)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: outstanding burst counts, address-phase waits, mode 0=run 1=drain 2=halted.
  int m_rd, m_wr, m_mode;
  bit m_ar_wait, m_aw_wait, m_err;
  bit ar_fwd, aw_fwd, ar_take, aw_take, r_end, b_end, busy_now;

  function automatic bit ar_open();
    return ((m_mode == 0) && (m_rd < Max)) || m_ar_wait;
  endfunction

  function automatic bit aw_open();
    return ((m_mode == 0) && (m_wr < Max)) || m_aw_wait;
  endfunction

  function automatic bit m_busy();
    return (m_rd != 0) || (m_wr != 0) || m_ar_wait || m_aw_wait;
  endfunction

  always @(posedge clk_i) begin
    if (rst_i) begin
      m_rd = 0; m_wr = 0; m_mode = 0;
      m_ar_wait = 0; m_aw_wait = 0; m_err = 0;
    end else begin
      ar_fwd   = slv_req.ar_valid && ar_open();
      aw_fwd   = slv_req.aw_valid && aw_open();
      ar_take  = ar_fwd && mst_resp.ar_ready;
      aw_take  = aw_fwd && mst_resp.aw_ready;
      r_end    = mst_resp.r_valid && slv_req.r_ready && mst_resp.r.last;
      b_end    = mst_resp.b_valid && slv_req.b_ready;
      busy_now = m_busy();
      if (ar_take && !r_end) m_rd++;
      else if (r_end && !ar_take) begin
        if (m_rd == 0) m_err = 1; else m_rd--;
      end
      if (aw_take && !b_end) m_wr++;
      else if (b_end && !aw_take) begin
        if (m_wr == 0) m_err = 1; else m_wr--;
      end
      m_ar_wait = ar_fwd && !mst_resp.ar_ready;
      m_aw_wait = aw_fwd && !mst_resp.aw_ready;
      case (m_mode)
        0:       if (stall_i) m_mode = 1;
        1:       if (!stall_i) m_mode = 0; else if (!busy_now) m_mode = 2;
        default: if (!stall_i) m_mode = 0;
      endcase
    end
  end

  req_t  exp_req;
  resp_t exp_resp;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      exp_req           = slv_req;
      exp_req.ar_valid  = slv_req.ar_valid & ar_open();
      exp_req.aw_valid  = slv_req.aw_valid & aw_open();
      exp_resp          = mst_resp;
      exp_resp.ar_ready = mst_resp.ar_ready & ar_open();
      exp_resp.aw_ready = mst_resp.aw_ready & aw_open();
      check("mst_req",  256'(mst_req),  256'(exp_req));
      check("slv_resp", 256'(slv_resp), 256'(exp_resp));
      check("rd_cnt",   256'(rd_cnt),   256'(m_rd));
      check("wr_cnt",   256'(wr_cnt),   256'(m_wr));
      check("busy",     256'(busy),     256'(m_busy()));
      check("halted",   256'(halted),   256'(m_mode == 2));
      check("err",      256'(err),      256'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    slv_req.w.data   = {$urandom, $urandom};
    slv_req.ar.addr  = {$urandom, $urandom};
    mst_resp.r.data  = {$urandom, $urandom};
    mst_resp.b.id    = 4'($urandom);
  endtask

  initial begin
    slv_req  = '0;
    mst_resp = '0;
    stall_i  = 1'b0;
    rst_i    = 1'b1;
    repeat (2) tick();
    rst_i = 1'b0;
    check("reset_rd",     256'(rd_cnt), 256'(0));
    check("reset_wr",     256'(wr_cnt), 256'(0));
    check("reset_busy",   256'(busy),   256'(0));
    check("reset_halted", 256'(halted), 256'(0));
    check("reset_err",    256'(err),    256'(0));

    // Three 4-beat read bursts.
    slv_req.ar_valid   = 1'b1;
    slv_req.ar.len     = 8'd3;
    mst_resp.ar_ready  = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("rd_ramp", 256'(rd_cnt), 256'(i));
    end
    slv_req.ar_valid = 1'b0;
    slv_req.r_ready  = 1'b1;
    mst_resp.r_valid = 1'b1;
    for (int b = 0; b < 12; b++) begin
      mst_resp.r.last = ((b % 4) == 3);
      if (b == 11) check("busy_before_last", 256'(busy), 256'(1));
      tick();
      if ((b % 4) == 3) check("rd_fall", 256'(rd_cnt), 256'(2 - b / 4));
    end
    check("busy_after_last", 256'(busy), 256'(0));
    mst_resp.r_valid = 1'b0;
    mst_resp.r.last  = 1'b0;

    // Simultaneous AR and R-last at rd_cnt=2.
    slv_req.ar_valid = 1'b1;
    tick();
    tick();
    check("rd_two", 256'(rd_cnt), 256'(2));
    mst_resp.r_valid = 1'b1;
    mst_resp.r.last  = 1'b1;
    tick();
    check("rd_simul_hold", 256'(rd_cnt), 256'(2));
    slv_req.ar_valid = 1'b0;
    tick();
    tick();
    check("rd_drained", 256'(rd_cnt), 256'(0));
    mst_resp.r_valid = 1'b0;
    mst_resp.r.last  = 1'b0;

    // Write limit: the 9th AW waits for a B.
    mst_resp.aw_ready = 1'b1;
    slv_req.aw_valid  = 1'b1;
    repeat (8) tick();
    check("wr_peak", 256'(wr_cnt), 256'(8));
    #1;
    check("aw_ready_at_max", 256'(slv_resp.aw_ready), 256'(0));
    check("aw_valid_at_max", 256'(mst_req.aw_valid),  256'(0));
    tick();
    check("wr_hold_max", 256'(wr_cnt), 256'(8));
    mst_resp.b_valid = 1'b1;
    slv_req.b_ready  = 1'b1;
    tick();
    mst_resp.b_valid = 1'b0;
    check("wr_after_b", 256'(wr_cnt), 256'(7));
    #1;
    check("ninth_aw_ready", 256'(slv_resp.aw_ready), 256'(1));
    tick();
    check("wr_repeak", 256'(wr_cnt), 256'(8));
    slv_req.aw_valid = 1'b0;
    mst_resp.b_valid = 1'b1;
    repeat (8) tick();
    mst_resp.b_valid = 1'b0;
    check("wr_drained", 256'(wr_cnt), 256'(0));

    // Stall while an AR is stuck waiting for ready.
    slv_req.ar_valid  = 1'b1;
    mst_resp.ar_ready = 1'b0;
    tick();
    stall_i = 1'b1;
    tick();
    #1;
    check("ar_valid_held",  256'(mst_req.ar_valid), 256'(1));
    check("drain_not_halt", 256'(halted),           256'(0));
    tick();
    tick();
    check("ar_valid_held2", 256'(mst_req.ar_valid), 256'(1));
    mst_resp.ar_ready = 1'b1;
    tick();
    slv_req.ar_valid = 1'b0;
    check("rd_in_drain", 256'(rd_cnt), 256'(1));
    mst_resp.r_valid = 1'b1;
    mst_resp.r.last  = 1'b1;
    tick();
    mst_resp.r_valid = 1'b0;
    mst_resp.r.last  = 1'b0;
    check("rd_zero_drain", 256'(rd_cnt), 256'(0));
    tick();
    check("halted_after_drain", 256'(halted), 256'(1));

    // Halted blocks AR until stall drops.
    slv_req.ar_valid = 1'b1;
    #1;
    check("halt_ar_valid", 256'(mst_req.ar_valid),  256'(0));
    check("halt_ar_ready", 256'(slv_resp.ar_ready), 256'(0));
    tick();
    check("halt_rd_zero", 256'(rd_cnt), 256'(0));
    stall_i = 1'b0;
    tick();
    check("resume_halted", 256'(halted), 256'(0));
    #1;
    check("resume_ar_fwd", 256'(mst_req.ar_valid), 256'(1));
    tick();
    slv_req.ar_valid = 1'b0;
    check("resume_rd", 256'(rd_cnt), 256'(1));
    mst_resp.r_valid = 1'b1;
    mst_resp.r.last  = 1'b1;
    tick();
    mst_resp.r_valid = 1'b0;
    mst_resp.r.last  = 1'b0;

    // Stall raised and released inside DRAIN with a write outstanding.
    slv_req.aw_valid = 1'b1;
    tick();
    slv_req.aw_valid = 1'b0;
    stall_i = 1'b1;
    tick();
    tick();
    stall_i = 1'b0;
    tick();
    check("blip_wr",  256'(wr_cnt), 256'(1));
    check("blip_err", 256'(err),    256'(0));
    mst_resp.b_valid = 1'b1;
    tick();
    mst_resp.b_valid = 1'b0;
    check("blip_wr_done", 256'(wr_cnt), 256'(0));

    // Stray B with nothing outstanding.
    mst_resp.b_valid = 1'b1;
    tick();
    mst_resp.b_valid = 1'b0;
    check("stray_b_err", 256'(err),    256'(1));
    check("stray_b_wr",  256'(wr_cnt), 256'(0));
    repeat (3) tick();
    check("err_sticky", 256'(err), 256'(1));
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("err_cleared", 256'(err), 256'(0));
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_drain_gate.md
AXI_DRAIN_GATE -- requirements
Module: axi_drain_gate

Interface
REQ-001 SHALL have parameter MaxOutstanding, default 8: maximum in-flight read bursts and, separately, in-flight write bursts (2..255).
REQ-002 SHALL have parameter CntWidth, default $clog2(MaxOutstanding+1): width of each outstanding counter.
REQ-003 SHALL have port clk_i, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port stall_i, input, 1: request to stop issuing new AR/AW and drain.
REQ-006 SHALL have port slv_req_i, input, ariane_axi::req_t: AXI request from the cache subsystem master port.
REQ-007 SHALL have port slv_resp_o, output, ariane_axi::resp_t: AXI response to the cache subsystem.
REQ-008 SHALL have port mst_req_o, output, ariane_axi::req_t: AXI request to the memory interconnect.
REQ-009 SHALL have port mst_resp_i, input, ariane_axi::resp_t: AXI response from the memory interconnect.
REQ-010 SHALL have port busy_o, output, 1: any transaction pending or in flight.
REQ-011 SHALL have port halted_o, output, 1: drained and blocked.
REQ-012 SHALL have port rd_cnt_o / wr_cnt_o, output, CntWidth each: current outstanding read / write bursts.
REQ-013 SHALL have port err_o, output, 1: sticky protocol error (response without an outstanding request).

Function
REQ-014 W, R and B channels SHALL pass through combinationally, unmodified, zero latency.
REQ-015 AR payload SHALL pass through; mst ar_valid = slv ar_valid & ~ar_block; slv ar_ready = mst ar_ready & ~ar_block. AW is identical with aw_block.
REQ-016 ar_block SHALL be ((state != RUN) | rd_cnt == MaxOutstanding) & ~ar_pend_q; aw_block is identical using wr_cnt and aw_pend_q.
REQ-017 ar_pend_q SHALL set when mst ar_valid & ~mst ar_ready and clear on AR handshake, so a forwarded valid is never withdrawn (AXI stability) even if stall_i rises or a limit is hit.
REQ-018 rd_cnt SHALL +1 on AR handshake and -1 on R handshake with r.last; both in the same cycle SHALL leave it unchanged.
REQ-019 wr_cnt SHALL +1 on AW handshake and -1 on B handshake; simultaneous events SHALL net to zero.
REQ-020 A decrement when the counter is 0 (and no increment that cycle) SHALL leave it at 0 and set err_o until reset.
REQ-021 The FSM SHALL have states RUN, DRAIN and HALTED.
REQ-022 FSM transitions: RUN->DRAIN on stall_i. DRAIN->RUN on ~stall_i. DRAIN->HALTED when stall_i & ~busy_o. HALTED->RUN on ~stall_i. Each transition takes one cycle.
REQ-023 busy_o SHALL be (rd_cnt != 0) | (wr_cnt != 0) | ar_pend_q | aw_pend_q, combinational from registers.
REQ-024 halted_o SHALL equal (state == HALTED), registered.
REQ-025 A stall asserted and released within DRAIN SHALL never drop an accepted transaction or create a counter error.

Reset
REQ-026 On rst_i: state=RUN, rd_cnt=wr_cnt=0, ar_pend_q=aw_pend_q=0, err_o=0; busy_o=0 and halted_o=0 from the following cycle.
REQ-027 Reset mid-transaction SHALL discard all tracking; the environment must reset both AXI sides together.

Structure
REQ-028 The state enum axi_gate_state_e {RUN, DRAIN, HALTED} SHALL live in std_cache_pkg; all AXI types SHALL come from ariane_axi.
REQ-029 One sub-module, outstanding_cnt (inputs inc/dec, outputs cnt/at_max/underflow), SHALL be instantiated twice: once for reads, once for writes.

Verification
REQ-030 Reset, then 3 AR bursts of len 3 with r.last on each 4th beat -> rd_cnt goes 0,1,2,3 and back to 0; busy_o falls the cycle after the last r.last.
REQ-031 MaxOutstanding=8, 9 AW issued with no B -> 9th aw_ready held 0; one B returned -> 9th accepted the next cycle; wr_cnt peaks at 8.
REQ-032 mst ar_ready=0 while ar_valid high, stall_i raised -> mst ar_valid stays 1 until handshake; state goes RUN->DRAIN; HALTED once rd_cnt returns to 0.
REQ-033 In HALTED, slv ar_valid=1 -> mst ar_valid=0 and slv ar_ready=0; stall_i dropped -> RUN next cycle and AR forwarded.
REQ-034 B response injected with wr_cnt=0 -> err_o=1 sticky, wr_cnt stays 0; rst_i -> err_o=0.
REQ-035 AR handshake and r.last handshake in the same cycle with rd_cnt=2 -> rd_cnt remains 2.
